mips_mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU datapath, and a debug/loader port (program load and memory inspection from switches or a host).
- Issues at most one memory access per cycle.
- Routes synchronous read data back to the owner and freezes the CPU via a stall output while it is denied.
- Supports an exclusive lock so the loader can rewrite program memory safely.

---
 rtl/mips_mem_arbiter.sv | 113 +++++++++++
 tb/tb_mips_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the multicycle MIPS core's single-port unified memory between the
// CPU datapath and a debug/loader port, with starvation relief and an exclusive lock.
module mips_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_locked,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {UNLOCKED, DRAIN, LOCKED} lock_state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    lock_state_t state, state_nxt;
    logic [3:0]  starve_cnt;
    logic        vld_p1;
    logic        own_dbg_p1;
    logic        cpu_rd_inflight;

    // Grants are also held off while reset is asserted so nothing reaches memory.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            case (state)
                UNLOCKED: begin
                    dbg_gnt = dbg_req && ((starve_cnt == LIMIT) || !cpu_req);
                    cpu_gnt = cpu_req && !dbg_gnt;
                end
                default: dbg_gnt = dbg_req;
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);

    // A CPU read is outstanding until its rvalid pulse has left the pipeline.
    assign cpu_rd_inflight = (vld_p1 & ~own_dbg_p1) | cpu_rvalid;

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (dbg_lock) state_nxt = DRAIN;
            DRAIN: begin
                if (!dbg_lock)             state_nxt = UNLOCKED;
                else if (!cpu_rd_inflight) state_nxt = LOCKED;
            end
            LOCKED:   if (!dbg_lock) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            dbg_locked <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            dbg_locked <= (state_nxt == LOCKED);
            if (!dbg_req || dbg_gnt)
                starve_cnt <= '0;
            else if (cpu_gnt && (starve_cnt != LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Issue -> p1: remember read owner; p1 -> p2: capture memory data and pulse rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            own_dbg_p1 <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            vld_p1     <= (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
            own_dbg_p1 <= dbg_gnt;
            cpu_rvalid <= vld_p1 & ~own_dbg_p1;
            dbg_rvalid <= vld_p1 & own_dbg_p1;
            if (vld_p1 && !own_dbg_p1) cpu_rdata <= mem_rdata;
            if (vld_p1 && own_dbg_p1)  dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: instance 0 uses STARVE_LIMIT=4, instance 1 STARVE_LIMIT=1.
module tb_mips_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req[2], cpu_we[2], dbg_req[2], dbg_we[2], dbg_lock[2];
    logic [AW-1:0] cpu_addr[2], dbg_addr[2], mem_addr[2];
    logic [DW-1:0] cpu_wdata[2], dbg_wdata[2], mem_wdata[2], mem_rdata[2];
    logic [DW-1:0] cpu_rdata[2], dbg_rdata[2];
    logic          cpu_gnt[2], cpu_stall[2], cpu_rvalid[2], dbg_locked[2];
    logic          dbg_gnt[2], dbg_rvalid[2], mem_we[2];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    typedef struct {
        int          inst;
        bit          dbg;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h01:   return 32'h11111111;
            8'h02:   return 32'h22222222;
            8'h03:   return 32'h33333333;
            8'h10:   return 32'hDEADBEEF;
            default: return {24'h0BAD00, a};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        mips_mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(g == 0 ? 4 : 1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_stall(cpu_stall[g]),
            .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
            .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
            .dbg_wdata(dbg_wdata[g]), .dbg_lock(dbg_lock[g]), .dbg_locked(dbg_locked[g]),
            .dbg_gnt(dbg_gnt[g]), .dbg_rvalid(dbg_rvalid[g]), .dbg_rdata(dbg_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );

        // Synchronous-read memory: unwritten words return fixed contents.
        logic [255:0]  written;
        logic [DW-1:0] store [256];
        always @(posedge clk) begin
            if (reset) begin
                written <= '0;
            end else if (mem_we[g]) begin
                store[mem_addr[g]]   <= mem_wdata[g];
                written[mem_addr[g]] <= 1'b1;
            end
            mem_rdata[g] <= written[mem_addr[g]] ? store[mem_addr[g]] : init_word(mem_addr[g]);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int g, input bit dbg, input logic [31:0] data);
        exp_t e;
        e.inst = g;
        e.dbg  = dbg;
        e.data = data;
        e.due  = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input int g, input logic req, input logic we,
                           input logic [7:0] a, input logic [31:0] d);
        cpu_req[g] = req; cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = d;
    endtask

    task automatic set_dbg(input int g, input logic req, input logic we,
                           input logic [7:0] a, input logic [31:0] d);
        dbg_req[g] = req; dbg_we[g] = we; dbg_addr[g] = a; dbg_wdata[g] = d;
    endtask

    // Monitor: every rvalid pulse pops one expected read and checks owner, data and timing.
    exp_t        mon_e;
    bit          mon_dbg;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cpu_rvalid[g] || dbg_rvalid[g]) begin
                vectors++;
                if (cpu_rvalid[g] && dbg_rvalid[g]) begin
                    errors++;
                    $display("FAIL rvalid both owners: inst %0d cycle %0d, required one-hot", g, cyc);
                end else if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected rvalid: inst %0d dbg=%0d cycle %0d, required none",
                             g, dbg_rvalid[g], cyc);
                end else begin
                    mon_e   = sbq.pop_front();
                    mon_dbg = dbg_rvalid[g];
                    mon_act = mon_dbg ? dbg_rdata[g] : cpu_rdata[g];
                    if (mon_e.inst != g || mon_e.dbg != mon_dbg || mon_e.data !== mon_act ||
                        mon_e.due != cyc) begin
                        errors++;
                        $display("FAIL read return: got inst %0d dbg=%0d data %h cycle %0d, expected inst %0d dbg=%0d data %h cycle %0d",
                                 g, mon_dbg, mon_act, cyc, mon_e.inst, mon_e.dbg, mon_e.data, mon_e.due);
                    end
                end
            end
        end
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            vectors++;
            errors++;
            $display("FAIL missing rvalid: got none by cycle %0d, expected inst %0d dbg=%0d data %h at cycle %0d",
                     cyc, sbq[0].inst, sbq[0].dbg, sbq[0].data, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion well before %0t", $time);
        $fatal(1);
    end

    initial begin
        int  n_cpu;
        bit  got, seen_rv, locked;
        for (int g = 0; g < 2; g++) begin
            set_cpu(g, 0, 0, 8'h00, 32'h0);
            set_dbg(g, 0, 0, 8'h00, 32'h0);
            dbg_lock[g] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset cpu_gnt", cpu_gnt[g], 0);
            check("reset dbg_gnt", dbg_gnt[g], 0);
            check("reset mem_we", mem_we[g], 0);
            check("reset dbg_locked", dbg_locked[g], 0);
            check("reset rvalids", {cpu_rvalid[g], dbg_rvalid[g]}, 0);
            check("reset rdata", cpu_rdata[g] | dbg_rdata[g], 0);
        end
        step();
        reset = 1'b0;
        step();

        // Test 6: write enable without request never reaches memory
        set_cpu(0, 0, 1, 8'h55, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 mem_we idle", mem_we[0], 0);
            check("t6 no grant", {cpu_gnt[0], dbg_gnt[0]}, 0);
            step();
        end
        set_cpu(0, 0, 0, 8'h00, 32'h0);

        // Test 1: single CPU read
        set_cpu(0, 1, 0, 8'h10, 32'h0);
        @(negedge clk);
        check("t1 cpu_gnt", cpu_gnt[0], 1);
        check("t1 mem_addr", mem_addr[0], 8'h10);
        check("t1 mem_we", mem_we[0], 0);
        check("t1 cpu_stall", cpu_stall[0], 0);
        push(0, 0, 32'hDEADBEEF);
        step();
        set_cpu(0, 0, 0, 8'h10, 32'h0);
        repeat (3) step();
        @(negedge clk);
        check("t1 cpu_rdata held", cpu_rdata[0], 32'hDEADBEEF);
        check("t1 dbg_rdata", dbg_rdata[0], 0);
        step();

        // Test 2: starvation relief after STARVE_LIMIT=4 CPU grants
        set_cpu(0, 1, 0, 8'h01, 32'h0);
        set_dbg(0, 1, 1, 8'h20, 32'h12345678);
        n_cpu = 0;
        got   = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (dbg_gnt[0]) begin
                got = 1;
                check("t2 cpu grants before dbg", n_cpu, 4);
                check("t2 mem_we", mem_we[0], 1);
                check("t2 mem_addr", mem_addr[0], 8'h20);
                check("t2 mem_wdata", mem_wdata[0], 32'h12345678);
                check("t2 cpu_stall", cpu_stall[0], 1);
                check("t2 cpu_gnt one-hot", cpu_gnt[0], 0);
            end else if (cpu_gnt[0]) begin
                n_cpu++;
                push(0, 0, 32'h11111111);
            end
            step();
        end
        check("t2 dbg granted", got, 1);
        set_dbg(0, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        check("t2 cpu regranted", cpu_gnt[0], 1);
        if (cpu_gnt[0]) push(0, 0, 32'h11111111);
        step();
        set_cpu(0, 0, 0, 8'h00, 32'h0);
        set_dbg(0, 1, 0, 8'h20, 32'h0);
        @(negedge clk);
        check("t2 dbg readback gnt", dbg_gnt[0], 1);
        push(0, 1, 32'h12345678);
        step();
        set_dbg(0, 0, 0, 8'h00, 32'h0);
        repeat (3) step();

        // Test 3: back-to-back CPU/dbg/CPU reads on the STARVE_LIMIT=1 instance
        set_cpu(1, 1, 0, 8'h01, 32'h0);
        set_dbg(1, 1, 0, 8'h02, 32'h0);
        @(negedge clk);
        check("t3 first cpu_gnt", cpu_gnt[1], 1);
        push(1, 0, 32'h11111111);
        step();
        cpu_addr[1] = 8'h03;
        @(negedge clk);
        check("t3 dbg_gnt", dbg_gnt[1], 1);
        check("t3 mem_addr dbg", mem_addr[1], 8'h02);
        check("t3 cpu_stall", cpu_stall[1], 1);
        push(1, 1, 32'h22222222);
        step();
        set_dbg(1, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        check("t3 second cpu_gnt", cpu_gnt[1], 1);
        check("t3 mem_addr cpu", mem_addr[1], 8'h03);
        push(1, 0, 32'h33333333);
        step();
        set_cpu(1, 0, 0, 8'h00, 32'h0);
        repeat (4) step();

        // Test 4: lock raised behind an in-flight CPU read
        set_cpu(0, 1, 0, 8'h10, 32'h0);
        @(negedge clk);
        check("t4 cpu_gnt", cpu_gnt[0], 1);
        push(0, 0, 32'hDEADBEEF);
        step();
        set_cpu(0, 0, 0, 8'h10, 32'h0);
        dbg_lock[0] = 1'b1;
        @(negedge clk);
        check("t4 not locked at raise", dbg_locked[0], 0);
        step();
        set_cpu(0, 1, 0, 8'h03, 32'h0);
        seen_rv = 0;
        locked  = 0;
        for (int i = 0; i < 10 && !locked; i++) begin
            @(negedge clk);
            check("t4 no cpu_gnt while draining", cpu_gnt[0], 0);
            if (dbg_locked[0]) begin
                locked = 1;
                check("t4 rvalid before lock", seen_rv, 1);
            end
            if (cpu_rvalid[0]) seen_rv = 1;
            step();
        end
        check("t4 lock reached", locked, 1);
        set_dbg(0, 1, 0, 8'h02, 32'h0);
        @(negedge clk);
        check("t4 dbg_gnt locked", dbg_gnt[0], 1);
        check("t4 cpu_stall locked", cpu_stall[0], 1);
        push(0, 1, 32'h22222222);
        step();
        set_dbg(0, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        check("t4 cpu_gnt locked", cpu_gnt[0], 0);
        check("t4 dbg_locked held", dbg_locked[0], 1);
        step();
        dbg_lock[0] = 1'b0;
        @(negedge clk);
        check("t4 cpu_gnt at drop", cpu_gnt[0], 0);
        step();
        @(negedge clk);
        check("t4 dbg_locked cleared", dbg_locked[0], 0);
        check("t4 cpu_gnt after unlock", cpu_gnt[0], 1);
        check("t4 mem_addr after unlock", mem_addr[0], 8'h03);
        push(0, 0, 32'h33333333);
        step();
        set_cpu(0, 0, 0, 8'h00, 32'h0);
        repeat (4) step();

        // Test 5: reset the cycle after a dbg read grant
        set_dbg(0, 1, 0, 8'h10, 32'h0);
        @(negedge clk);
        check("t5 dbg_gnt", dbg_gnt[0], 1);
        step();
        set_dbg(0, 0, 0, 8'h00, 32'h0);
        reset = 1'b1;
        #1;
        check("t5 grants in reset", {cpu_gnt[0], dbg_gnt[0]}, 0);
        check("t5 rvalids in reset", {cpu_rvalid[0], dbg_rvalid[0]}, 0);
        check("t5 dbg_rdata in reset", dbg_rdata[0], 0);
        check("t5 cpu_rdata in reset", cpu_rdata[0], 0);
        check("t5 mem_we in reset", mem_we[0], 0);
        step();
        reset = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("t5 dbg_rdata after release", dbg_rdata[0], 0);
        step();

        repeat (2) step();
        check("scoreboard drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
